// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet front-end: job layout, FSM states and
// the float constant also used by the core.
package maxnet_pkg;

  // A job is five float32 words: epsilon followed by four activations.
  localparam int JOB_LEN = 5;

  // Slot indices within the job buffer, in arrival order.
  localparam logic [2:0] SLOT_EPS = 3'd0;
  localparam logic [2:0] SLOT_A1  = 3'd1;
  localparam logic [2:0] SLOT_A2  = 3'd2;
  localparam logic [2:0] SLOT_A3  = 3'd3;
  localparam logic [2:0] SLOT_A4  = 3'd4;

  // IEEE-754 single-precision 1.0, shared with the core.
  localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // True when the write index points at the final word of a job.
  function automatic logic is_last_slot(input logic [2:0] idx);
    return (idx == SLOT_A4);
  endfunction

endpackage

// File: rtl/maxnet_feeder.sv
// MaxNet front-end sequencer: gathers a five-word job, pulses start on the
// core, waits for a fresh finish (or times out) and returns the result over
// a valid/ready stream. Data words pass through untouched.
module maxnet_feeder
  import maxnet_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data,
  output logic              res_timeout,
  output logic              core_start,
  output logic [WORD_W-1:0] core_eps,
  output logic [WORD_W-1:0] core_a1,
  output logic [WORD_W-1:0] core_a2,
  output logic [WORD_W-1:0] core_a3,
  output logic [WORD_W-1:0] core_a4,
  input  logic              core_finish,
  input  logic [WORD_W-1:0] core_out
);

  // Last counter value spent in WAIT before the job is abandoned.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_r, state_s;
  logic [2:0]        widx_r, widx_s;
  logic [WORD_W-1:0] slot_r [JOB_LEN];
  logic              wr_en_s;
  logic              seen_low_r, seen_low_s;
  logic [TO_W-1:0]   cnt_r, cnt_s;
  logic [WORD_W-1:0] res_data_r, res_data_s;
  logic              res_timeout_r, res_timeout_s;
  logic              in_ready_r, res_valid_r, core_start_r;
  logic              complete_s;

  // A finish only counts once the level has been seen low during this job,
  // so a level left high by the previous job cannot complete the new one.
  assign complete_s = core_finish & seen_low_r;

  // Next-state, slot write enable, timeout and result capture decisions.
  always_comb begin
    state_s       = state_r;
    widx_s        = widx_r;
    wr_en_s       = 1'b0;
    seen_low_s    = seen_low_r;
    cnt_s         = cnt_r;
    res_data_s    = res_data_r;
    res_timeout_s = res_timeout_r;
    case (state_r)
      ST_LOAD: begin
        if (in_valid && in_ready_r) begin
          wr_en_s = 1'b1;
          if (is_last_slot(widx_r)) begin
            widx_s  = 3'd0;
            state_s = ST_START;
          end else begin
            widx_s  = widx_r + 3'd1;
            state_s = ST_LOAD;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_START: begin
        seen_low_s = 1'b0;
        cnt_s      = '0;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        if (!core_finish) begin
          seen_low_s = 1'b1;
        end else begin
          seen_low_s = seen_low_r;
        end
        if (complete_s) begin
          res_data_s    = core_out;
          res_timeout_s = 1'b0;
          state_s       = ST_RESP;
        end else if (cnt_r == TO_LAST) begin
          res_data_s    = '0;
          res_timeout_s = 1'b1;
          state_s       = ST_RESP;
        end else begin
          cnt_s = cnt_r + TO_W'(1);
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  // FSM state, write index, finish qualifier, timeout counter and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_LOAD;
      widx_r        <= 3'd0;
      seen_low_r    <= 1'b0;
      cnt_r         <= '0;
      res_data_r    <= '0;
      res_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      widx_r        <= widx_s;
      seen_low_r    <= seen_low_s;
      cnt_r         <= cnt_s;
      res_data_r    <= res_data_s;
      res_timeout_r <= res_timeout_s;
    end
  end

  // Job slot storage; only written during LOAD, so it holds through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_r <= '{default: '0};
    end else if (wr_en_s) begin
      slot_r[widx_r] <= in_data;
    end
  end

  // Handshake and start outputs registered as decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r   <= 1'b1;
      res_valid_r  <= 1'b0;
      core_start_r <= 1'b0;
    end else begin
      in_ready_r   <= (state_s == ST_LOAD);
      res_valid_r  <= (state_s == ST_RESP);
      core_start_r <= (state_s == ST_START);
    end
  end

  assign in_ready    = in_ready_r;
  assign res_valid   = res_valid_r;
  assign core_start  = core_start_r;
  assign res_data    = res_data_r;
  assign res_timeout = res_timeout_r;
  assign core_eps    = slot_r[SLOT_EPS];
  assign core_a1     = slot_r[SLOT_A1];
  assign core_a2     = slot_r[SLOT_A2];
  assign core_a3     = slot_r[SLOT_A3];
  assign core_a4     = slot_r[SLOT_A4];

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder: a main instance with the default timeout
// and a second instance with a 16-cycle timeout whose core never finishes.
module tb_maxnet_feeder;

  typedef struct packed {
    logic [31:0] data;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, res_valid, res_ready, res_timeout;
  logic        core_start, core_finish;
  logic [31:0] in_data, res_data, core_out;
  logic [31:0] core_eps, core_a1, core_a2, core_a3, core_a4;

  logic        t_in_valid, t_in_ready, t_res_valid, t_res_ready, t_res_timeout;
  logic        t_core_start, t_core_finish;
  logic [31:0] t_in_data, t_res_data, t_core_out;
  logic [31:0] t_eps, t_a1, t_a2, t_a3, t_a4;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  maxnet_feeder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .core_start(core_start),
    .core_eps(core_eps), .core_a1(core_a1), .core_a2(core_a2),
    .core_a3(core_a3), .core_a4(core_a4),
    .core_finish(core_finish), .core_out(core_out)
  );

  maxnet_feeder #(.WORD_W(32), .TIMEOUT(16), .TO_W(5)) dut_t (
    .clk(clk), .rst(rst),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
    .res_valid(t_res_valid), .res_ready(t_res_ready), .res_data(t_res_data),
    .res_timeout(t_res_timeout), .core_start(t_core_start),
    .core_eps(t_eps), .core_a1(t_a1), .core_a2(t_a2),
    .core_a3(t_a3), .core_a4(t_a4),
    .core_finish(t_core_finish), .core_out(t_core_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_idle();
    chk("idle_in_ready", in_ready, 32'd1);
    chk("idle_res_valid", res_valid, 32'd0);
    chk("idle_core_start", core_start, 32'd0);
    chk("idle_res_data", res_data, 32'd0);
    chk("idle_res_timeout", res_timeout, 32'd0);
    chk("idle_eps", core_eps, 32'd0);
    chk("idle_a1", core_a1, 32'd0);
    chk("idle_a2", core_a2, 32'd0);
    chk("idle_a3", core_a3, 32'd0);
    chk("idle_a4", core_a4, 32'd0);
  endtask

  task automatic check_slots(input logic [31:0] w [5]);
    chk("slot_eps", core_eps, w[0]);
    chk("slot_a1", core_a1, w[1]);
    chk("slot_a2", core_a2, w[2]);
    chk("slot_a3", core_a3, w[3]);
    chk("slot_a4", core_a4, w[4]);
  endtask

  // Offers words first..4 (optional random idle gaps); returns in the cycle
  // after the last handshake, i.e. the cycle core_start should be high.
  task automatic send_job(input logic [31:0] w [5], input int first, input int max_gap,
                          input bit keep_valid, input logic [31:0] next_w);
    for (int i = first; i < 5; i++) begin
      int g;
      int n;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        step();
      end
      in_valid = 1'b1;
      in_data  = w[i];
      n = 0;
      while (!in_ready && n < 100) begin
        step();
        n++;
      end
      chk("load_in_ready", in_ready, 32'd1);
      step();
    end
    if (keep_valid) begin
      in_valid = 1'b1;
      in_data  = next_w;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Called in the START cycle S: drops finish at S+1, raises it at S+delay
  // and requires res_valid exactly one cycle later.
  task automatic run_core(input int delay, input logic [31:0] val);
    step();
    chk("start_single_pulse", core_start, 32'd0);
    core_finish = 1'b0;
    for (int k = 1; k < delay; k++) begin
      chk("busy_in_ready", in_ready, 32'd0);
      step();
    end
    chk("res_valid_early", res_valid, 32'd0);
    core_finish = 1'b1;
    core_out    = val;
    step();
    chk("res_valid_latency", res_valid, 32'd1);
  endtask

  // Pops the expected result, holds res_ready low for 'hold' cycles, then
  // completes the handshake and requires in_ready on the following cycle.
  task automatic get_result(input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!res_valid && n < 5000) begin
      step();
      n++;
    end
    chk("res_valid_seen", res_valid, 32'd1);
    chk("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("res_data", res_data, e.data);
    chk("res_timeout", res_timeout, {31'd0, e.to});
    res_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      step();
      chk("hold_res_valid", res_valid, 32'd1);
      chk("hold_res_data", res_data, e.data);
      chk("hold_in_ready", in_ready, 32'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("post_resp_in_ready", in_ready, 32'd1);
    chk("post_resp_res_valid", res_valid, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] job_a [5];
    logic [31:0] job_b [5];
    logic [31:0] job_c [5];
    logic [31:0] job_e [5];
    logic [31:0] job_f [5];
    exp_t        e;
    int          n;

    job_a = '{32'h3E4CCCCD, 32'h3F000000, 32'h3F666666, 32'h3E99999A, 32'h3DCCCCCD};
    job_b = '{32'h3C23D70A, 32'hBF800000, 32'h7F7FFFFF, 32'h00000001, 32'hFFC00000};
    job_c = '{32'h3D4CCCCD, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h3E800000};
    job_e = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    job_f = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678};

    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    core_finish = 1'b0; core_out = '0;
    t_in_valid = 1'b0; t_in_data = '0; t_res_ready = 1'b0;
    t_core_finish = 1'b0; t_core_out = 32'h12345678;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_idle();
    chk("t_reset_in_ready", t_in_ready, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Normal job: finish 20 cycles after start.
    sb.push_back({32'h3F666666, 1'b0});
    send_job(job_a, 0, 0, 1'b0, 32'h0);
    chk("start_after_last_word", core_start, 32'd1);
    check_slots(job_a);
    run_core(20, 32'h3F666666);
    get_result(0);

    // Input gaps and 10 cycles of result backpressure.
    sb.push_back({32'hC0490FDB, 1'b0});
    send_job(job_b, 0, 3, 1'b0, 32'h0);
    chk("gap_start", core_start, 32'd1);
    check_slots(job_b);
    run_core(7, 32'hC0490FDB);
    get_result(10);

    // Stale finish: level still high from the previous job across START.
    sb.push_back({32'h3F400000, 1'b0});
    send_job(job_c, 0, 0, 1'b0, 32'h0);
    chk("stale_start", core_start, 32'd1);
    chk("stale_finish_high", {31'd0, core_finish}, 32'd1);
    core_out = 32'h3F400000;
    step();
    step();
    chk("stale_no_early_complete", res_valid, 32'd0);
    core_finish = 1'b0;
    step();
    step();
    step();
    core_finish = 1'b1;
    chk("stale_still_waiting", res_valid, 32'd0);
    step();
    chk("stale_complete_on_rise", res_valid, 32'd1);
    get_result(0);

    // Timeout instance: 16 WAIT cycles, so res_valid 17 cycles after START.
    for (int i = 0; i < 5; i++) begin
      t_in_valid = 1'b1;
      t_in_data  = job_a[i];
      chk("t_in_ready", t_in_ready, 32'd1);
      step();
    end
    t_in_valid = 1'b0;
    chk("t_core_start", t_core_start, 32'd1);
    sb.push_back({32'h0, 1'b1});
    n = 0;
    while (!t_res_valid && n < 100) begin
      step();
      n++;
    end
    chk("t_cycles_to_res_valid", n, 32'd17);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("t_res_data", t_res_data, e.data);
    chk("t_res_timeout", {31'd0, t_res_timeout}, {31'd0, e.to});
    t_res_ready = 1'b1;
    step();
    t_res_ready = 1'b0;
    chk("t_post_in_ready", t_in_ready, 32'd1);

    // Reset asserted mid-WAIT discards the job.
    core_finish = 1'b0;
    send_job(job_c, 0, 0, 1'b0, 32'h0);
    step();
    step();
    chk("pre_reset_in_ready", in_ready, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check_idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("after_reset_in_ready", in_ready, 32'd1);

    // Busy rejection: next eps offered continuously from job E's last word.
    sb.push_back({32'h3F000000, 1'b0});
    send_job(job_e, 0, 0, 1'b1, job_f[0]);
    chk("busy_start", core_start, 32'd1);
    check_slots(job_e);
    run_core(5, 32'h3F000000);
    get_result(3);
    step();
    sb.push_back({32'h3E000000, 1'b0});
    send_job(job_f, 1, 0, 1'b0, 32'h0);
    chk("next_job_start", core_start, 32'd1);
    check_slots(job_f);
    run_core(4, 32'h3E000000);
    get_result(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxnet_feeder.md
# maxnet_feeder

Front-end sequencer that drives the MaxNet core's parameter/start side and collects its result. It accepts a packed job of five IEEE-754 single-precision words (epsilon, a1..a4) over a valid/ready input stream. It holds these words stable on the core's init inputs, issues a one-cycle start, and waits for the core's finish. It then returns the winner word, or a timeout flag, over a valid/ready result stream.

## Interface
Parameters:
- WORD_W, 32, data word width (float32)
- TIMEOUT, 4096, max WAIT cycles before abort
- TO_W, 13, width of timeout counter (≥ clog2(TIMEOUT))

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  job word valid
- in_ready  out  1  feeder accepts word
- in_data  in  WORD_W  job word; order eps, a1, a2, a3, a4
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  WORD_W  core out word (0 on timeout)
- res_timeout  out  1  1 = job aborted by timeout
- core_start  out  1  one-cycle start pulse to core
- core_eps, core_a1..core_a4  out  WORD_W each  held job words
- core_finish  in  1  core result valid (level)
- core_out  in  WORD_W  core result

## Operation
- States: LOAD, START, WAIT, RESP.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake writes in_data into slot widx, in order eps, a1, a2, a3, a4, and increments widx (3 bits).
  - Handshake with widx=4 → widx=0, go START.
- START:
  - core_start=1 for exactly this cycle.
  - Clear seen_low and the timeout counter.
  - Go WAIT.
- WAIT:
  - seen_low sets when core_finish=0.
  - Completion = core_finish=1 && seen_low. This rejects a finish level still high from the previous job.
  - On completion: capture core_out into res_data, res_timeout=0, go RESP.
  - Otherwise increment the counter. At count TIMEOUT-1 without completion: res_data=0, res_timeout=1, go RESP.
- RESP:
  - res_valid=1, with res_data and res_timeout held stable until res_ready.
  - On handshake go LOAD.
- core_eps/core_a* are driven from the slot registers and remain stable from START through RESP. They change only during LOAD.
- in_ready=0 outside LOAD. Words offered then are not consumed.
- No arithmetic on data; words pass through bit-exact.

## Timing
- Reset (async assert, sync deassert assumed upstream) returns:
  - state=LOAD, widx=0, all slots=0, in_ready=1
  - core_start=0, res_valid=0, res_data=0, res_timeout=0
  - seen_low=0, counter=0
- in_ready and res_valid are registered state decodes. core_start is registered.
- Latency:
  - Last job word accepted at cycle N → core_start high at N+1.
  - WAIT entered at N+2.
- core_finish qualifying at cycle M → res_valid high at M+1.
- Result consumed at cycle R → in_ready high at R+1.
- Earliest back-to-back job word accepted at R+1.
- Reset mid-job discards partial words and any pending result. The core is not restarted.

## Structure
- Package maxnet_pkg:
  - localparams for job length (5), slot indices, and the state enum.
  - FLOAT_ONE = 32'h3F800000 (shared with the core).
- Single module. Slot storage is a 5-entry register array; no sub-modules required.
- Timeout counter and seen_low live alongside the FSM.

## Test plan
- Normal job:
  - Stimulus: eps=0x3E4CCCCD, a1=0x3F000000, a2=0x3F666666, a3=0x3E99999A, a4=0x3DCCCCCD. Core model raises finish 20 cycles after start with out=0x3F666666.
  - Required: core_start is a single pulse one cycle after the 5th word; res_data=0x3F666666, res_timeout=0.
- Input gaps and result backpressure:
  - Stimulus: in_valid toggled randomly; res_ready held low for 10 cycles.
  - Required: all slots correct; res_valid and res_data stable for 10 cycles; no second job accepted meanwhile.
- Timeout:
  - Stimulus: core_finish never asserted, TIMEOUT=16.
  - Required: res_valid exactly 16 WAIT cycles after START; res_timeout=1, res_data=0.
- Stale finish:
  - Stimulus: core_finish held high across START, low 3 cycles, then high.
  - Required: completion only on the re-rise, not in the first WAIT cycle.
- Reset mid-WAIT:
  - Stimulus: rst low during WAIT.
  - Required: immediately state=LOAD, in_ready=1, res_valid=0, core_start=0, and all slots reported 0.
- Busy rejection:
  - Stimulus: in_valid=1 throughout START/WAIT/RESP.
  - Required: in_ready=0 throughout; the next job's first word is eps, accepted one cycle after the result handshake.
